shift_frame_engine: RTL and testbench
=====================================

SHIFT_FRAME_ENGINE -- requirements
Module: shift_frame_engine

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, shift register length in bits (legal 2..32).
REQ-002 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: serialClkposedge  input  1  one-clk-cycle strobe; qualifies every LOAD/SHIFT action.
REQ-005 SHALL have port: mode  input  2  00 HOLD, 01 LOAD, 10 SHIFT, 11 CLEAR.
REQ-006 SHALL have port: parallelIn  input  WIDTH  load data.
REQ-007 SHALL have port: serialIn  input  1  bit shifted into the vacated end.
REQ-008 SHALL have port: parallelOut  output  WIDTH  register contents.
REQ-009 SHALL have port: serialOut  output  1  outgoing bit; MSB-first: parallelOut[WIDTH-1]; LSB-first: parallelOut[0]; combinational from register.
REQ-010 SHALL have port: bitCount  output  $clog2(WIDTH+1)  bits shifted in current frame.
REQ-011 SHALL have port: busy  output  1  high while state is FRAME.
REQ-012 SHALL have port: frameDone  output  1  one-clk pulse when WIDTH-th bit of a frame shifts.

Function
REQ-013 SHALL implement states IDLE and FRAME; busy = (state == FRAME).
REQ-014 SHALL take no LOAD/SHIFT action on a clk edge where serialClkposedge = 0; HOLD keeps register, count, state.
REQ-015 LOAD with strobe SHALL set register <= parallelIn, bitCount <= 0, state <= FRAME, one-cycle latency.
REQ-016 LOAD with strobe while in FRAME SHALL abort the current frame and restart it (count 0, no frameDone).
REQ-017 SHIFT with strobe, MSB-first, SHALL set register <= {register[WIDTH-2:0], serialIn}.
REQ-018 SHIFT with strobe in FRAME SHALL increment bitCount; on the edge where bitCount would reach WIDTH: frameDone = 1 next cycle, bitCount <= 0, state <= IDLE.
REQ-019 SHIFT with strobe in IDLE SHALL shift the register but leave bitCount = 0 and frameDone = 0 (free-running mode).
REQ-020 CLEAR SHALL act regardless of strobe: register <= 0, bitCount <= 0, state <= IDLE, frameDone <= 0.
REQ-021 frameDone SHALL be high for exactly one clk cycle per completed frame, even if the next strobe arrives in the following cycle.
REQ-022 A LOAD strobe in the cycle right after frameDone SHALL start a new frame with no lost or extra bits (back-to-back frames).

Reset
REQ-023 reset SHALL be sampled only on the rising clk edge and SHALL override mode and strobe.
REQ-024 After reset: parallelOut = 0, serialOut = 0, bitCount = 0, busy = 0, frameDone = 0, state IDLE.
REQ-025 reset asserted mid-frame SHALL discard the frame with no frameDone pulse.

Configuration
REQ-026 Macro SHIFT_FRAME_LSBFIRST_EN SHALL add input port lsbFirst (1 bit), sampled on each SHIFT strobe.
REQ-027 With the macro and lsbFirst = 1, SHIFT SHALL set register <= {serialIn, register[WIDTH-1:1]} and serialOut = parallelOut[0].
REQ-028 Without the macro, port lsbFirst SHALL be absent and operation SHALL be MSB-first only.

Verification (WIDTH = 8)
REQ-029 reset with mode = LOAD and strobe high, parallelIn = 8'hFF -> parallelOut = 8'h00, busy = 0, frameDone = 0 on the next cycle.
REQ-030 LOAD 8'hA5, then 8 SHIFT strobes with serialIn = 1,0,1,0,0,1,0,1 -> serialOut sequence 1,0,1,0,0,1,0,1; final parallelOut = 8'hA5; single frameDone pulse; busy = 0.
REQ-031 LOAD 8'h0F, 3 SHIFT strobes with serialIn = 0, then LOAD 8'h3C -> bitCount = 0, busy = 1, parallelOut = 8'h3C, no frameDone.
REQ-032 LOAD 8'h81, SHIFT with serialClkposedge = 0 for 5 cycles -> parallelOut stays 8'h81, bitCount = 0.
REQ-033 Frame in progress with bitCount = 4, then CLEAR without strobe -> parallelOut = 0, busy = 0, no frameDone.
REQ-034 Macro defined, lsbFirst = 1: LOAD 8'h01, SHIFT with serialIn = 1 -> serialOut was 1 before the shift; parallelOut = 8'h80 after it.

Source files
------------

// File: rtl/shift_frame_engine.sv
// Framed shift register: LOAD starts a frame, WIDTH shifts finish it.
// Optional SHIFT_FRAME_LSBFIRST_EN adds an lsbFirst direction input.
module shift_frame_engine #(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       serialClkposedge,
  input  logic [1:0]                 mode,
  input  logic [WIDTH-1:0]           parallelIn,
  input  logic                       serialIn,
`ifdef SHIFT_FRAME_LSBFIRST_EN
  input  logic                       lsbFirst,
`endif
  output logic [WIDTH-1:0]           parallelOut,
  output logic                       serialOut,
  output logic [$clog2(WIDTH+1)-1:0] bitCount,
  output logic                       busy,
  output logic                       frameDone
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] HOLD  = 2'b00;
  localparam logic [1:0] LOAD  = 2'b01;
  localparam logic [1:0] SHIFT = 2'b10;
  localparam logic [1:0] CLEAR = 2'b11;

  typedef enum logic {IDLE, FRAME} state_t;

  state_t            state;
  logic [WIDTH-1:0]  shiftReg;
  logic [CW-1:0]     count;
  logic              done;
  logic              lsb;
  logic [WIDTH-1:0]  shifted;

  always_comb begin
`ifdef SHIFT_FRAME_LSBFIRST_EN
    lsb = lsbFirst;
`else
    lsb = 1'b0;
`endif
    shifted = lsb ? {serialIn, shiftReg[WIDTH-1:1]}
                  : {shiftReg[WIDTH-2:0], serialIn};
  end

  // CLEAR ignores the strobe; LOAD/SHIFT need it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shiftReg <= '0;
      count    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mode == CLEAR) begin
        state    <= IDLE;
        shiftReg <= '0;
        count    <= '0;
      end else if (serialClkposedge) begin
        case (mode)
          LOAD: begin
            shiftReg <= parallelIn;
            count    <= '0;
            state    <= FRAME;
          end
          SHIFT: begin
            shiftReg <= shifted;
            if (state == FRAME) begin
              if (count == LAST) begin
                count <= '0;
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                count <= count + CW'(1);
              end
            end
          end
          HOLD: ;
          default: ;
        endcase
      end
    end
  end

  assign parallelOut = shiftReg;
  assign serialOut   = lsb ? shiftReg[0] : shiftReg[WIDTH-1];
  assign bitCount    = count;
  assign busy        = (state == FRAME);
  assign frameDone   = done;

endmodule

// File: tb/tb_shift_frame_engine.sv
// Randomized + directed bench for shift_frame_engine (WIDTH = 8).
// A frame-level model is compared against the DUT on every negedge.
module tb_shift_frame_engine;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         strobe = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] pIn = '0;
  logic         sIn = 1'b0;
`ifdef SHIFT_FRAME_LSBFIRST_EN
  logic         lsbFirst = 1'b0;
`endif
  logic [W-1:0] pOut;
  logic         sOut;
  logic [3:0]   bitCount;
  logic         busy;
  logic         frameDone;

  int passCount = 0;
  int checkCount = 0;

  shift_frame_engine #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .serialClkposedge(strobe),
    .mode(mode),
    .parallelIn(pIn),
    .serialIn(sIn),
`ifdef SHIFT_FRAME_LSBFIRST_EN
    .lsbFirst(lsbFirst),
`endif
    .parallelOut(pOut),
    .serialOut(sOut),
    .bitCount(bitCount),
    .busy(busy),
    .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  function automatic bit lsbNow();
`ifdef SHIFT_FRAME_LSBFIRST_EN
    return lsbFirst;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level reference: value, bits-in-frame, in-frame flag, done pulse.
  int mReg = 0;
  int mCnt = 0;
  bit mInFrame = 0;
  bit mDone = 0;

  always @(posedge clk) begin
    mDone = 0;
    if (reset || mode == 2'b11) begin
      mReg = 0;
      mCnt = 0;
      mInFrame = 0;
    end else if (strobe && mode == 2'b01) begin
      mReg = int'(pIn);
      mCnt = 0;
      mInFrame = 1;
    end else if (strobe && mode == 2'b10) begin
      if (lsbNow())
        mReg = (mReg / 2) + (int'(sIn) * 128);
      else
        mReg = ((mReg * 2) + int'(sIn)) % 256;
      if (mInFrame) begin
        mCnt = mCnt + 1;
        if (mCnt == W) begin
          mCnt = 0;
          mInFrame = 0;
          mDone = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model.parallelOut", int'(pOut), mReg);
    check("model.serialOut", int'(sOut),
          lsbNow() ? (mReg % 2) : (mReg / 128));
    check("model.bitCount", int'(bitCount), mCnt);
    check("model.busy", int'(busy), int'(mInFrame));
    check("model.frameDone", int'(frameDone), int'(mDone));
  end

  task automatic drive(input logic [1:0] m, input logic st,
                       input logic [W-1:0] p, input logic s);
    mode = m;
    strobe = st;
    pIn = p;
    sIn = s;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [7:0] bits;

  initial begin
    #2;
    // Reset overrides a strobed LOAD.
    reset = 1'b1;
    drive(2'b01, 1'b1, 8'hFF, 1'b0);
    step();
    step();
    check("rst.parallelOut", int'(pOut), 8'h00);
    check("rst.busy", int'(busy), 0);
    check("rst.frameDone", int'(frameDone), 0);
    check("rst.serialOut", int'(sOut), 0);
    reset = 1'b0;

    // Full frame: A5 shifted out and back in.
    bits = 8'hA5;
    drive(2'b01, 1'b1, 8'hA5, 1'b0);
    step();
    check("frame.busy", int'(busy), 1);
    for (int i = 0; i < 8; i++) begin
      check("frame.serialOut", int'(sOut), int'(bits[7-i]));
      drive(2'b10, 1'b1, 8'h00, bits[7-i]);
      step();
      check("frame.frameDone", int'(frameDone), (i == 7) ? 1 : 0);
    end
    check("frame.parallelOut", int'(pOut), 8'hA5);
    check("frame.busyEnd", int'(busy), 0);

    // Back-to-back: LOAD right in the frameDone cycle.
    drive(2'b01, 1'b1, 8'h5A, 1'b0);
    step();
    check("b2b.busy", int'(busy), 1);
    check("b2b.bitCount", int'(bitCount), 0);
    check("b2b.frameDone", int'(frameDone), 0);
    for (int i = 0; i < 8; i++) begin
      drive(2'b10, 1'b1, 8'h00, 1'b0);
      step();
    end
    check("b2b.frameDoneEnd", int'(frameDone), 1);
    check("b2b.parallelOut", int'(pOut), 8'h00);

    // Restart mid-frame.
    drive(2'b01, 1'b1, 8'h0F, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 1'b1, 8'h00, 1'b0);
      step();
    end
    check("restart.bitCount3", int'(bitCount), 3);
    check("restart.shifted", int'(pOut), 8'h78);
    drive(2'b01, 1'b1, 8'h3C, 1'b0);
    step();
    check("restart.bitCount", int'(bitCount), 0);
    check("restart.busy", int'(busy), 1);
    check("restart.parallelOut", int'(pOut), 8'h3C);
    check("restart.frameDone", int'(frameDone), 0);

    // Unstrobed SHIFT holds.
    drive(2'b01, 1'b1, 8'h81, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, 1'b0, 8'h00, 1'b1);
      step();
    end
    check("nostrobe.parallelOut", int'(pOut), 8'h81);
    check("nostrobe.bitCount", int'(bitCount), 0);

    // CLEAR without strobe mid-frame.
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, 1'b1, 8'h00, 1'b1);
      step();
    end
    check("clear.bitCount4", int'(bitCount), 4);
    drive(2'b11, 1'b0, 8'h00, 1'b0);
    step();
    check("clear.parallelOut", int'(pOut), 0);
    check("clear.busy", int'(busy), 0);
    check("clear.frameDone", int'(frameDone), 0);

    // Free-running shift in IDLE does not count.
    drive(2'b10, 1'b1, 8'h00, 1'b1);
    step();
    check("idle.bitCount", int'(bitCount), 0);
    check("idle.parallelOut", int'(pOut), 8'h01);

    // Reset mid-frame: no pulse.
    drive(2'b01, 1'b1, 8'hC3, 1'b0);
    step();
    for (int i = 0; i < 7; i++) begin
      drive(2'b10, 1'b1, 8'h00, 1'b1);
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst.frameDone", int'(frameDone), 0);
    check("midrst.busy", int'(busy), 0);
    check("midrst.parallelOut", int'(pOut), 0);

`ifdef SHIFT_FRAME_LSBFIRST_EN
    lsbFirst = 1'b1;
    drive(2'b01, 1'b1, 8'h01, 1'b0);
    step();
    check("lsb.serialOutBefore", int'(sOut), 1);
    drive(2'b10, 1'b1, 8'h00, 1'b1);
    step();
    check("lsb.parallelOut", int'(pOut), 8'h80);
    lsbFirst = 1'b0;
`endif

    // Randomized traffic, shifts weighted to complete frames.
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      reset = ($urandom_range(0, 199) == 0);
      if (r < 12) mode = 2'b01;
      else if (r < 85) mode = 2'b10;
      else if (r < 90) mode = 2'b11;
      else mode = 2'b00;
      strobe = ($urandom_range(0, 3) != 0);
      pIn = W'($urandom);
      sIn = 1'($urandom);
`ifdef SHIFT_FRAME_LSBFIRST_EN
      lsbFirst = 1'($urandom);
`endif
      step();
    end
    reset = 1'b0;
    drive(2'b00, 1'b0, 8'h00, 1'b0);
    step();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
